audio_capture_packer: RTL
=========================

# audio_capture_packer

Capture path from the audio codec input (line-in/mic) back to the HPS. Accepts left and right 24-bit samples from the audio-in L and R FIFOs, pairs them L-then-R, and buffers the pairs. Emits each pair as two 32-bit left-justified words (L first) on the stream toward the HPS FIFO, with full valid/ready backpressure in both directions.

## Interface
- SAMPLE_W, 24: audio sample width, signed two's complement.
- WORD_W, 32: HPS stream word width. Must be ≥ SAMPLE_W.
- PAIR_DEPTH, 4: buffered L/R pairs. Power of two, ≥ 2.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  capture enable.
- valid_in_audioL  in  1  left sample valid.
- ready_out_audioL  out  1  left sample accepted this cycle when valid also high.
- stream_inL  in  SAMPLE_W  left sample.
- valid_in_audioR  in  1  right sample valid.
- ready_out_audioR  out  1  right sample ready.
- stream_inR  in  SAMPLE_W  right sample.
- valid_out_fifo  out  1  output word valid.
- ready_in_fifo  in  1  HPS FIFO can accept.
- stream_out  out  WORD_W  output word.
- LEDS  out  10  level meter. Tied to 0 when the meter is compiled out.

## Operation
- Input FSM, states IN_L and IN_R; reset to IN_L.
  - IN_L: ready_out_audioL = enable. On an L handshake, latch the sample into the hold register and go to IN_R.
  - IN_R: ready_out_audioR = !pair_full; ready_out_audioL = 0. On an R handshake, write {hold, stream_inR} into the pair buffer and go to IN_L.
- enable low in IN_R: the pending R is still accepted, then the FSM parks in IN_L. Pairs are never split.
- Pair buffer: PAIR_DEPTH x 2·SAMPLE_W, with registered count, full and empty flags. Full backpressures the input; samples are never dropped.
- Output FSM, states OUT_L and OUT_R; reset to OUT_L.
  - valid_out_fifo = !pair_empty.
  - OUT_L: stream_out = {head.L, zeros}.
  - OUT_R: stream_out = {head.R, zeros}. The sample occupies the MSBs; the low WORD_W−SAMPLE_W bits are 0.
  - OUT_L handshake: go to OUT_R. OUT_R handshake: pop the head and go to OUT_L.
- While valid_out_fifo is high and not accepted, stream_out holds stable.
- Simultaneous push and pop: both occur and the count is unchanged. The push decision uses the registered pair_full, so there is no same-cycle bypass when full.

## Timing
- Reset values:
  - ready_out_audioL = 0, then follows enable from the first cycle after reset.
  - ready_out_audioR = 0, valid_out_fifo = 0, stream_out = 0 (empty buffer reads as 0), LEDS = 0.
  - Buffer count, both FSMs and the meter peak are cleared.
- Latency: R handshake at edge N puts valid_out_fifo high after edge N (cycle N+1), from an empty buffer.
- Throughput: 1 input sample per cycle and 1 output word per cycle with continuous ready.
- reset mid-pair or mid-output discards the hold register and all buffered pairs, with no partial word afterward.

## Configuration
- LEVEL_METER_EN defined:
  - Each accepted L or R sample updates peak = max(peak, |sample|). |−2^(SAMPLE_W−1)| saturates to 2^(SAMPLE_W−1)−1.
  - Every 2^20 clk cycles, peak shifts right by 1 (decay). Decay and update in the same cycle: the update wins.
  - LEDS[i] = (peak ≥ 2^(SAMPLE_W−11+i)) for i = 0..9, registered, giving a thermometer code.
- LEVEL_METER_EN undefined: LEDS = 10'h0 and no meter logic is synthesized.

## Structure
- Shared package audio_pkg:
  - SAMPLE_W/WORD_W defaults.
  - Sample and pair struct typedefs.
  - Input and output FSM state enums.
  - Meter decay exponent (20) and LED base-threshold constant.
- One sub-module, audio_pair_fifo: synchronous, registered full, empty and count, read-head combinational output. All other logic stays in the top.

## Test plan
- Basic pair: after reset, enable = 1; L = 24'h123456, R = 24'hABCDEF; ready_in_fifo = 1 -> stream_out 32'h12345600 then 32'hABCDEF00 on consecutive cycles. First valid appears the cycle after the R handshake.
- Full backpressure: ready_in_fifo = 0, stream 5 pairs -> after 4 pairs, the 5th L is latched and ready_out_audioR = 0. Releasing ready -> 10 words out in exact L,R order and no loss.
- Output stall: drop ready_in_fifo in OUT_R for 3 cycles -> stream_out and valid_out_fifo are held constant; the next word after resume is the next pair's L.
- enable drop: deassert enable in IN_R -> R is still accepted and the pair is emitted; ready_out_audioL stays 0 until enable returns.
- Reset mid-operation: reset with 2 pairs buffered and OUT_R pending -> valid_out_fifo = 0 the next cycle. The next pair emits L first.
- LEVEL_METER_EN: sample 24'h800000 -> LEDS = 10'h3FF. After 2^20 idle cycles -> LEDS = 10'h1FF.

Source files
------------

// File: rtl/audio_capture_packer_pkg.sv
// Shared definitions for the audio capture packer: default widths, sample and
// pair types, input/output FSM state encodings and level-meter constants.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W  = 24;
  localparam int AUDIO_WORD_W    = 32;

  // Meter decays by one bit every 2^METER_DECAY_EXP clock cycles.
  localparam int METER_DECAY_EXP = 20;
  // LED 0 lights at 2^(SAMPLE_W - LED_BASE_OFFSET); each further LED doubles.
  localparam int LED_BASE_OFFSET = 11;
  localparam int LED_COUNT       = 10;

  typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } pair_t;

  typedef enum logic {
    IN_L = 1'b0,
    IN_R = 1'b1
  } in_state_e;

  typedef enum logic {
    OUT_L = 1'b0,
    OUT_R = 1'b1
  } out_state_e;

endpackage

// File: rtl/audio_capture_packer_if.sv
// Stream bundle of the capture packer: L and R sample inputs from the codec
// FIFOs and the word stream toward the HPS FIFO. The packer uses the slave
// modport; the producer/consumer side uses master.
interface audio_capture_packer_if #(
  parameter int SAMPLE_W = 24,
  parameter int WORD_W   = 32
);
  logic                valid_in_audioL;
  logic                ready_out_audioL;
  logic [SAMPLE_W-1:0] stream_inL;
  logic                valid_in_audioR;
  logic                ready_out_audioR;
  logic [SAMPLE_W-1:0] stream_inR;
  logic                valid_out_fifo;
  logic                ready_in_fifo;
  logic [WORD_W-1:0]   stream_out;

  modport slave (
    input  valid_in_audioL, stream_inL,
    input  valid_in_audioR, stream_inR,
    input  ready_in_fifo,
    output ready_out_audioL, ready_out_audioR,
    output valid_out_fifo, stream_out
  );

  modport master (
    output valid_in_audioL, stream_inL,
    output valid_in_audioR, stream_inR,
    output ready_in_fifo,
    input  ready_out_audioL, ready_out_audioR,
    input  valid_out_fifo, stream_out
  );
endinterface

// File: rtl/audio_capture_packer_pair_fifo.sv
// Synchronous pair FIFO for the capture packer. Count, full and empty are
// registered; the head entry is presented combinationally and reads as zero
// when the FIFO is empty.
module audio_pair_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == {(AW+1){1'b0}});
    end
  end

  // Storage array; contents beyond the valid range are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_empty ? {W{1'b0}} : r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/audio_capture_packer.sv
// Audio capture packer: pairs L then R samples from the codec input FIFOs,
// buffers whole pairs and emits each as two left-justified words (L first)
// toward the HPS FIFO, with valid/ready backpressure on both sides.
// Optional peak level meter on LEDS is built when LEVEL_METER_EN is defined.
module audio_capture_packer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = AUDIO_SAMPLE_W,
  parameter int WORD_W     = AUDIO_WORD_W,
  parameter int PAIR_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  audio_capture_packer_if.slave  bus,
  output logic [LED_COUNT-1:0]   LEDS
);

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } pair_w_t;

  in_state_e           r_in_state;
  in_state_e           w_in_state_nxt;
  out_state_e          r_out_state;
  out_state_e          w_out_state_nxt;

  logic [SAMPLE_W-1:0] r_hold;
  logic                w_ready_l;
  logic                w_ready_r;
  logic                w_hs_l;
  logic                w_hs_r;
  logic                w_push;
  logic                w_pop;
  logic                w_out_hs;

  pair_w_t             w_wpair;
  pair_w_t             w_head;
  logic                w_full;
  logic                w_empty;
  logic [SAMPLE_W-1:0] w_out_sample;

  assign w_hs_l   = bus.valid_in_audioL & w_ready_l;
  assign w_hs_r   = bus.valid_in_audioR & w_ready_r;
  assign w_out_hs = ~w_empty & bus.ready_in_fifo;

  // Input FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_in_state <= IN_L;
    else       r_in_state <= w_in_state_nxt;
  end

  // Input FSM: take L while enabled, then always complete the pair with R.
  always_comb begin
    w_in_state_nxt = r_in_state;
    w_ready_l      = 1'b0;
    w_ready_r      = 1'b0;
    w_push         = 1'b0;
    case (r_in_state)
      IN_L: begin
        w_ready_l = enable & ~reset;
        if (bus.valid_in_audioL & enable & ~reset) w_in_state_nxt = IN_R;
        else                                       w_in_state_nxt = IN_L;
      end
      IN_R: begin
        w_ready_r = ~w_full & ~reset;
        if (bus.valid_in_audioR & ~w_full & ~reset) begin
          w_push         = 1'b1;
          w_in_state_nxt = IN_L;
        end else begin
          w_in_state_nxt = IN_R;
        end
      end
      default: w_in_state_nxt = IN_L;
    endcase
  end

  // Hold register for the left sample awaiting its right partner.
  always_ff @(posedge clk) begin
    if (reset)       r_hold <= {SAMPLE_W{1'b0}};
    else if (w_hs_l) r_hold <= bus.stream_inL;
    else             r_hold <= r_hold;
  end

  assign w_wpair.l = r_hold;
  assign w_wpair.r = bus.stream_inR;

  audio_pair_fifo #(
    .W     (2*SAMPLE_W),
    .DEPTH (PAIR_DEPTH)
  ) u_pair_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wpair),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Output FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_out_state <= OUT_L;
    else       r_out_state <= w_out_state_nxt;
  end

  // Output FSM: L word then R word of the head pair; pop after the R word.
  always_comb begin
    w_out_state_nxt = r_out_state;
    w_pop           = 1'b0;
    case (r_out_state)
      OUT_L: begin
        if (w_out_hs) w_out_state_nxt = OUT_R;
        else          w_out_state_nxt = OUT_L;
      end
      OUT_R: begin
        if (w_out_hs) begin
          w_pop           = 1'b1;
          w_out_state_nxt = OUT_L;
        end else begin
          w_out_state_nxt = OUT_R;
        end
      end
      default: w_out_state_nxt = OUT_L;
    endcase
  end

  assign w_out_sample = (r_out_state == OUT_R) ? w_head.r : w_head.l;

  // Left-justify: sample in the MSBs, zero fill below.
  assign bus.stream_out       = WORD_W'(w_out_sample) << (WORD_W - SAMPLE_W);
  assign bus.valid_out_fifo   = ~w_empty;
  assign bus.ready_out_audioL = w_ready_l;
  assign bus.ready_out_audioR = w_ready_r;

`ifdef LEVEL_METER_EN
  logic [SAMPLE_W-2:0]        r_peak;
  logic [METER_DECAY_EXP-1:0] r_decay_cnt;
  logic [LED_COUNT-1:0]       r_leds;
  logic [SAMPLE_W-1:0]        w_meter_sample;
  logic [SAMPLE_W-2:0]        w_mag;
  logic                       w_meter_hs;
  logic [LED_COUNT-1:0]       w_thermo;

  // Magnitude of a signed sample; the most negative value saturates.
  function automatic logic [SAMPLE_W-2:0] abs_sat(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = (~s) + SAMPLE_W'(1);
    if (!s[SAMPLE_W-1])                         return s[SAMPLE_W-2:0];
    else if (s[SAMPLE_W-2:0] == {(SAMPLE_W-1){1'b0}}) return {(SAMPLE_W-1){1'b1}};
    else                                        return neg[SAMPLE_W-2:0];
  endfunction

  assign w_meter_hs     = w_hs_l | w_hs_r;
  assign w_meter_sample = w_hs_l ? bus.stream_inL : bus.stream_inR;
  assign w_mag          = abs_sat(w_meter_sample);

  // Thermometer code of the current peak.
  always_comb begin
    w_thermo = {LED_COUNT{1'b0}};
    for (int i = 0; i < LED_COUNT; i++) begin
      w_thermo[i] = ({1'b0, r_peak} >= (SAMPLE_W'(1) << (SAMPLE_W - LED_BASE_OFFSET + i)));
    end
  end

  // Peak tracking with periodic decay; a sample update overrides decay.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak      <= {(SAMPLE_W-1){1'b0}};
      r_decay_cnt <= {METER_DECAY_EXP{1'b0}};
      r_leds      <= {LED_COUNT{1'b0}};
    end else begin
      r_decay_cnt <= r_decay_cnt + METER_DECAY_EXP'(1);
      if (w_meter_hs) begin
        if (w_mag > r_peak) r_peak <= w_mag;
        else                r_peak <= r_peak;
      end else if (r_decay_cnt == {METER_DECAY_EXP{1'b1}}) begin
        r_peak <= r_peak >> 1;
      end else begin
        r_peak <= r_peak;
      end
      r_leds <= w_thermo;
    end
  end

  assign LEDS = r_leds;
`else
  assign LEDS = 10'h0;
`endif

endmodule
